// File: rtl/ascon_pkg.sv
// Shared types, widths and helper functions for the Ascon permutation controller.
package ascon_pkg;

  localparam int STATE_W    = 320;
  localparam int WORD_W     = 64;
  localparam int MAX_ROUNDS = 12;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Round constant: upper nibble counts down from 15 while the lower nibble counts up.
  function automatic logic [7:0] rc(input logic [3:0] r);
    return {4'(4'd15 - r), r};
  endfunction

  // Right rotation of one 64-bit state word.
  function automatic logic [WORD_W-1:0] ror64(input logic [WORD_W-1:0] x, input int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

endpackage

// File: rtl/ascon_round.sv
// One Ascon round, purely combinational: constant addition, bitsliced S-box,
// then linear diffusion.
module ascon_round
  import ascon_pkg::*;
(
  input  logic [STATE_W-1:0] s_i,
  input  logic [3:0]         r_i,
  output logic [STATE_W-1:0] s_o
);

  logic [WORD_W-1:0] x0, x1, x2, x3, x4;
  logic [WORD_W-1:0] t0, t1, t2, t3, t4;
  logic [WORD_W-1:0] y0, y1, y2, y3, y4;

  // Constant addition and the bitsliced 5-bit S-box across all 64 columns.
  always_comb begin
    x0 = s_i[319:256];
    x1 = s_i[255:192];
    x2 = s_i[191:128] ^ {56'h0, rc(r_i)};
    x3 = s_i[127:64];
    x4 = s_i[63:0];

    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;

    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;

    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;

    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;
  end

  // Linear diffusion: each word XORed with two right rotations of itself.
  always_comb begin
    y0 = x0 ^ ror64(x0, 19) ^ ror64(x0, 28);
    y1 = x1 ^ ror64(x1, 61) ^ ror64(x1, 39);
    y2 = x2 ^ ror64(x2, 1)  ^ ror64(x2, 6);
    y3 = x3 ^ ror64(x3, 10) ^ ror64(x3, 17);
    y4 = x4 ^ ror64(x4, 7)  ^ ror64(x4, 41);
    s_o = {y0, y1, y2, y3, y4};
  end

endmodule

// File: rtl/ascon_perm_ctrl.sv
// Iterative Ascon permutation controller: one round per clock, owns the state
// register, round index, remaining-round counter and the done pulse.
module ascon_perm_ctrl #(
  parameter int MAX_ROUNDS = ascon_pkg::MAX_ROUNDS
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [3:0]                     nrounds,
  input  logic [ascon_pkg::STATE_W-1:0]  state_in,
  output logic                           busy,
  output logic                           done,
  output logic [ascon_pkg::STATE_W-1:0]  state_out
);

  ascon_pkg::state_t               state_q;
  logic [ascon_pkg::STATE_W-1:0]   s_q;
  logic [ascon_pkg::STATE_W-1:0]   s_d;
  logic [3:0]                      r_q;
  logic [3:0]                      c_q;
  logic                            busy_q;
  logic                            done_q;
  logic [3:0]                      n_eff;

  // Out-of-range round requests (0 or above MAX_ROUNDS) run the full permutation.
  always_comb begin
    n_eff = nrounds;
    if (nrounds == 4'd0 || nrounds > 4'(MAX_ROUNDS)) begin
      n_eff = 4'(MAX_ROUNDS);
    end
  end

  ascon_round u_round (
    .s_i (s_q),
    .r_i (r_q),
    .s_o (s_d)
  );

  // Controller FSM with registered busy/done; the done cycle is an IDLE cycle,
  // so a start there is accepted without a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ascon_pkg::IDLE;
      s_q     <= '0;
      r_q     <= '0;
      c_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ascon_pkg::IDLE: begin
          if (start) begin
            s_q     <= state_in;
            r_q     <= 4'(MAX_ROUNDS) - n_eff;
            c_q     <= n_eff;
            busy_q  <= 1'b1;
            state_q <= ascon_pkg::RUN;
          end
        end
        ascon_pkg::RUN: begin
          s_q <= s_d;
          r_q <= r_q + 4'd1;
          c_q <= c_q - 4'd1;
          if (c_q == 4'd1) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ascon_pkg::IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ascon_pkg::IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign state_out = s_q;

endmodule

// File: doc/ascon_perm_ctrl.md
# ascon_perm_ctrl

Iterative controller for the 320-bit Ascon permutation. It accepts a state and a round count, then applies one full round per clock: constant addition, then substitution layer, then linear diffusion. It signals completion with a one-cycle pulse. It sits between the AEAD/hash mode FSM and the round datapath, and is the only block that drives the permutation state register.

## Interface
Parameters:
- MAX_ROUNDS, 12: number of rounds in p^a; round-constant indexing is relative to this value.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a permutation; sampled only in IDLE.
- nrounds  in  4  rounds to apply (1..12); sampled with start.
- state_in  in  320  input state {x0,x1,x2,x3,x4}, x0 in [319:256]; sampled with start.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse; state_out is the final result in that cycle.
- state_out  out  320  current state register; holds the last result until the next accepted start.

## Operation
- States: IDLE and RUN.
- IDLE, start=1:
  - load state_in into S;
  - set round index r = 12 - n, where n is nrounds clamped: 0 and 13..15 are treated as 12;
  - set remaining count c = n;
  - go to RUN.
- IDLE, start=0: hold S.
- RUN, each cycle:
  - S <= round(S, r); r <= r+1; c <= c-1;
  - when c==1, the update is the last round: go to IDLE and assert done in the next cycle.
- Round constant for index r: {4'(15-r), 4'(r)}, XORed into x2[7:0] only.
  - Sequence for r=0..11: f0 e1 d2 c3 b4 a5 96 87 78 69 5a 4b.
- Substitution layer: bitsliced Ascon 5-bit S-box applied across all 64 columns. The x0..x4 bit-i column forms one 5-bit input, with x0 as the MSB.
- Linear diffusion is the fixed per-word rotation layer; all rotations are right rotations:
  - x0: 19, 28
  - x1: 61, 39
  - x2: 1, 6
  - x3: 10, 17
  - x4: 7, 41
- done is registered:
  - high exactly one cycle, in the first IDLE cycle after the last round;
  - never high in RUN.
- start while busy=1 is ignored; nrounds and state_in are not resampled.
- start in the same cycle as done is accepted, giving back-to-back operation with no bubble.
- rst, whether in IDLE or mid-RUN:
  - next cycle: IDLE, S=0, r=0, c=0, busy=0, done=0;
  - an aborted permutation never produces done.
- Reset value of every output: busy=0, done=0, state_out=320'h0.

## Timing
- start is sampled at edge k.
- Rounds execute at edges k+1 .. k+n.
- busy is high for cycles k+1 .. k+n (n cycles).
- done is high in cycle k+n+1, so latency from the start edge to done is n+1 cycles.
- Throughput: one permutation per n+1 cycles when start is held high.
- state_out is valid from the done cycle until the edge after the next accepted start.
- Combinational path per cycle is one round: XOR, S-box, linear layer. There is no other pipelining.

## Structure
- Shared package ascon_pkg:
  - STATE_W=320, WORD_W=64, MAX_ROUNDS=12;
  - round-constant function rc(r);
  - state-enum type {IDLE, RUN}.
- Natural sub-module: ascon_round, purely combinational, with inputs S[319:0] and r[3:0] and output S'[319:0]. It implements constant addition, then S-box, then linear diffusion.
- ascon_perm_ctrl owns the FSM, r and c counters, the S register and done.

## Test plan
- Reset and idle:
  - assert rst 2 cycles with start=1 and random state_in;
  - then busy=0, done=0, state_out=0, and no activity until start.
- Single round, n=1, state_in=0:
  - done arrives 2 cycles after the start edge;
  - busy is high 1 cycle;
  - state_out equals the software model of one round with constant 0x4b.
- Full permutation:
  - n=12 and n=6 on random states, compared to the software Ascon model;
  - first-round constants are 0xf0 (n=12) and 0x96 (n=6); n=8 starts at 0xb4;
  - done cycles are 13 and 7 after the start edge.
- Clamp: nrounds=0 and nrounds=15 behave identically to nrounds=12 (same result, done 13 cycles after start).
- Back-to-back and ignored start:
  - hold start=1 with changing state_in;
  - starts during busy are ignored;
  - a new start is accepted in each done cycle;
  - each result matches the model of the state_in sampled at the accepting edge.
- Reset mid-operation:
  - n=12, assert rst at the 5th RUN cycle;
  - next cycle busy=0, state_out=0, and no done pulse;
  - a subsequent start with n=6 completes correctly.
